// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply and radix-2 restoring divide, DATA_W iterations
// plus one sign-fixup cycle. Signed ops run on magnitudes and fix signs at the end.
// Optional MADD/MSUB accumulation is enabled by defining MIPS_MDU_MAC_EN;
// without it ops 110/111 complete immediately as no-ops.
module mips_muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  // Architectural and working state
  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   opb_q, opb_d;          // multiplicand / divisor magnitude
  logic [DATA_W-1:0]   wk_hi_q, wk_hi_d;      // partial product high / partial remainder
  logic [DATA_W-1:0]   wk_lo_q, wk_lo_d;      // multiplier bits / dividend-quotient shifter
  logic [DATA_W-1:0]   dvd_q, dvd_d;          // raw dividend, returned in HI on divide by zero
  logic                neg_res_q, neg_res_d;  // product / quotient must be negated
  logic                neg_rem_q, neg_rem_d;  // remainder must be negated
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // Request decode and operand magnitude conversion
  logic                accept_c;
  logic                op_signed_c;
  logic                a_neg_c, b_neg_c;
  logic [DATA_W-1:0]   a_mag_c, b_mag_c;

  // Iteration datapath
  logic                is_div_c;
  logic [DATA_W:0]     mul_sum_c;
  logic [DATA_W:0]     div_rs_c;
  logic [DATA_W-1:0]   div_diff_c;
  logic                div_ge_c;

  // Sign fixup datapath
  logic [PROD_W-1:0]   prod_s_c;
  logic [DATA_W-1:0]   quo_s_c, rem_s_c;
  logic                div_zero_c;
`ifdef MIPS_MDU_MAC_EN
  logic [PROD_W-1:0]   acc_c;
`endif

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Request acceptance and signed-operand magnitudes
  always_comb begin
    accept_c    = req_valid && req_ready;
    op_signed_c = (req_op == OP_MULT) || (req_op == OP_DIV) ||
                  (req_op == OP_MADD) || (req_op == OP_MSUB);
    a_neg_c     = op_signed_c && req_a[DATA_W-1];
    b_neg_c     = op_signed_c && req_b[DATA_W-1];
    a_mag_c     = a_neg_c ? (DATA_W'(0) - req_a) : req_a;
    b_mag_c     = b_neg_c ? (DATA_W'(0) - req_b) : req_b;
  end

  // One radix-2 step of shift-add multiply and restoring divide
  always_comb begin
    is_div_c   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mul_sum_c  = {1'b0, wk_hi_q} +
                 (wk_lo_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
    div_rs_c   = {wk_hi_q, wk_lo_q[DATA_W-1]};
    div_ge_c   = (div_rs_c >= {1'b0, opb_q});
    div_diff_c = DATA_W'(div_rs_c - {1'b0, opb_q});
  end

  // Sign application for the final result
  always_comb begin
    prod_s_c   = neg_res_q ? (PROD_W'(0) - {wk_hi_q, wk_lo_q}) : {wk_hi_q, wk_lo_q};
    quo_s_c    = neg_res_q ? (DATA_W'(0) - wk_lo_q) : wk_lo_q;
    rem_s_c    = neg_rem_q ? (DATA_W'(0) - wk_hi_q) : wk_hi_q;
    div_zero_c = (opb_q == '0);
`ifdef MIPS_MDU_MAC_EN
    acc_c      = {hi_q, lo_q};
`endif
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opb_d     = opb_q;
    wk_hi_d   = wk_hi_q;
    wk_lo_d   = wk_lo_q;
    dvd_d     = dvd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d      = req_op;
          opb_d     = b_mag_c;
          wk_hi_d   = '0;
          wk_lo_d   = a_mag_c;
          dvd_d     = req_a;
          neg_res_d = a_neg_c ^ b_neg_c;
          neg_rem_d = a_neg_c;
          unique case (req_op)
            OP_MTHI: begin
              hi_d   = req_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_a;
              done_d = 1'b1;
            end
            OP_MADD, OP_MSUB: begin
`ifdef MIPS_MDU_MAC_EN
              state_d = ST_ITER;
              cnt_d   = CNT_W'(DATA_W);
`else
              done_d  = 1'b1;
`endif
            end
            default: begin
              state_d = ST_ITER;
              cnt_d   = CNT_W'(DATA_W);
            end
          endcase
        end
      end

      ST_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (is_div_c) begin
            wk_hi_d = div_ge_c ? div_diff_c : div_rs_c[DATA_W-1:0];
            wk_lo_d = {wk_lo_q[DATA_W-2:0], div_ge_c};
          end else begin
            wk_hi_d = mul_sum_c[DATA_W:1];
            wk_lo_d = {mul_sum_c[0], wk_lo_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        // A flush in this cycle discards the result entirely
        if (!flush) begin
          done_d = 1'b1;
          unique case (op_q)
            OP_DIV, OP_DIVU: begin
              if (div_zero_c) begin
                hi_d = dvd_q;
                lo_d = '1;
              end else begin
                hi_d = rem_s_c;
                lo_d = quo_s_c;
              end
            end
`ifdef MIPS_MDU_MAC_EN
            OP_MADD: {hi_d, lo_d} = acc_c + prod_s_c;
            OP_MSUB: {hi_d, lo_d} = acc_c - prod_s_c;
`endif
            default: {hi_d, lo_d} = prod_s_c;
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      opb_q     <= '0;
      wk_hi_q   <= '0;
      wk_lo_q   <= '0;
      dvd_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opb_q     <= opb_d;
      wk_hi_q   <= wk_hi_d;
      wk_lo_q   <= wk_lo_d;
      dvd_q     <= dvd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus pushes expected HI/LO and
// completion cycle; a monitor pops and compares on every done pulse.
module tb_mips_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

`ifdef MIPS_MDU_MAC_EN
  localparam int unsigned MAC_LAT = LAT;
`else
  localparam int unsigned MAC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  mips_muldiv_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [31:0]  cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned last_acc;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t  e;
    string nm;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, "_hi"}, hi, e.hi);
        chk({nm, "_lo"}, lo, e.lo);
        chk({nm, "_done_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input string nm, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input int unsigned lat);
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    last_acc  = cyc + 1;
    if (push) begin
      exp_q.push_back({eh, el, 32'(last_acc + lat)});
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int nb;
    int k;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hi",   hi, 32'h0);
    chk("rst_lo",   lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // MULT -3*5 with a request presented (and ignored) while busy
    issue("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT);
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (i == 3) chk("ready_while_busy", 32'(req_ready), 32'd0);
      req_valid = (i == 3);
      req_op    = 3'b101;
      req_a     = 32'h0000_1234;
    end
    req_valid = 1'b0;
    chk("mult_busy_cycles", 32'(nb), 32'd33);

    // Multiply and divide vectors, issued back to back in each done cycle
    issue("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, LAT);
    issue("mult_negneg", 3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 1'b1, 32'h0, 32'h18, LAT);
    issue("div_neg7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT);
    issue("div_7_neg2", 3'b010, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h1, 32'hFFFF_FFFD, LAT);
    issue("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, LAT);
    issue("div_zero", 3'b010, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, LAT);
    issue("divu_100_7", 3'b011, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, LAT);
    issue("divu_zero", 3'b011, 32'd100, 32'd0, 1'b1, 32'd100, 32'hFFFF_FFFF, LAT);

    // Flush on edge E10 of a DIVU: no result, no done, ready right after
    issue("divu_flushed", 3'b011, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 0);
    k = 0;
    while (cyc != last_acc + 9 && k < 100) begin
      @(negedge clk);
      k++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_busy",  32'(busy), 32'd0);
    chk("flush_hi", hi, 32'd100);
    chk("flush_lo", lo, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    chk("flush_hi_late", hi, 32'd100);

    // Flush in IDLE blocks acceptance
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'b101;
    req_a     = 32'h55;
    #1;
    chk("idle_flush_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_lo",   lo, 32'hFFFF_FFFF);
    chk("idle_flush_busy", 32'(busy), 32'd0);

    // Moves and accumulate
    issue("mtlo", 3'b101, 32'h10, 32'h0, 1'b1, 32'd100, 32'h10, 0);
    issue("mthi", 3'b100, 32'h0, 32'h0, 1'b1, 32'h0, 32'h10, 0);
`ifdef MIPS_MDU_MAC_EN
    issue("madd", 3'b110, 32'd2, 32'd3, 1'b1, 32'h0, 32'h16, MAC_LAT);
    issue("msub_negb", 3'b111, 32'hFFFF_FFFF, 32'h20, 1'b1, 32'h0, 32'h36, MAC_LAT);
    issue("msub_wrap", 3'b111, 32'd1, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF6, MAC_LAT);
`else
    issue("madd_nop", 3'b110, 32'd2, 32'd3, 1'b1, 32'h0, 32'h10, MAC_LAT);
    issue("msub_nop", 3'b111, 32'hFFFF_FFFF, 32'h20, 1'b1, 32'h0, 32'h10, MAC_LAT);
`endif

    // Reset in the middle of a MULT
    issue("mult_reset", 3'b000, 32'd3, 32'd3, 1'b0, 32'h0, 32'h0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi",   hi, 32'h0);
    chk("midrst_lo",   lo, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset
    issue("multu_after_rst", 3'b001, 32'd3, 32'd3, 1'b1, 32'h0, 32'd9, LAT);

    // Drain outstanding expectations
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
